// File: rtl/cla_serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the nibble-serial CLA subtractor:
//   - state_e : controller states (IDLE, RUN, DONE)
//   - NIB     : bits handled per clock by the look-ahead slice
//   - nslices : number of nibble slices needed for a given operand width
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operand widths are whole nibbles, so this is an exact division.
  function automatic int nslices(input int width);
    return width / NIB;
  endfunction

endpackage

// File: rtl/cla_serial_sub_cla4_slice.sv
// ---------------------------------------------------------------------------
// cla4_slice
// Purely combinational 4-bit carry-look-ahead adder slice.
// Ports:
//   x  [3:0] in  : first addend
//   y  [3:0] in  : second addend
//   ci       in  : carry in
//   s  [3:0] out : sum
//   co       out : carry out (look-ahead c4)
// ---------------------------------------------------------------------------
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  // Generate and propagate terms for each bit position.
  assign g = x & y;
  assign p = x ^ y;

  // Every carry is expanded directly from g/p/ci so no carry ripples
  // through a previous carry output.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  // Sum bits combine each propagate term with the carry into that bit.
  assign s  = p ^ {c3, c2, c1, ci};
  assign co = c4;

endmodule

// File: rtl/cla_serial_sub.sv
// ---------------------------------------------------------------------------
// cla_serial_sub
// Nibble-serial two's-complement subtractor: diff = a - b - borrow_in
// (modulo 2^WIDTH). One 4-bit slice is processed per clock through a single
// cla4_slice; the inter-slice carry lives in a register. Subtraction is done
// as a + ~b + ~borrow_in, so a final carry of 0 means a borrow occurred.
//
// Parameters:
//   WIDTH           operand width, a multiple of 4 and at least 4
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  block idle and able to take operands
//   a          in   minuend   [WIDTH-1:0]
//   b          in   subtrahend [WIDTH-1:0]
//   borrow_in  in   incoming borrow
//   out_valid  out  result valid (held until out_ready)
//   out_ready  in   consumer takes the result
//   diff       out  a - b - borrow_in [WIDTH-1:0]
//   borrow_out out  unsigned a < b + borrow_in
//   overflow   out  signed overflow
//
// Build option:
//   CLA_SUB_OVERFLOW_EN  when defined, overflow is computed from the latched
//                        operand MSBs and the final diff MSB; otherwise the
//                        overflow port is tied low and no MSB latches exist.
// ---------------------------------------------------------------------------
module cla_serial_sub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int N    = nslices(WIDTH);
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNTW-1:0]  sliceCnt_q;
  logic [CNTW-1:0]  sliceCnt_d;
  logic             carry_q;
  logic             carry_d;
  logic [WIDTH-1:0] aOp_q;
  logic [WIDTH-1:0] aOp_d;
  logic [WIDTH-1:0] bOp_q;
  logic [WIDTH-1:0] bOp_d;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_q;
  logic             borrow_d;

  logic [NIB-1:0]   sliceX;
  logic [NIB-1:0]   sliceY;
  logic [NIB-1:0]   sliceSum;
  logic             sliceCo;
  logic             accept;
  logic             lastSlice;

  // Handshake flags come straight from the state register so they never
  // depend combinationally on any input.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign lastSlice = (sliceCnt_q == LAST);

  // The slice sees the current nibble of a and the inverted nibble of b;
  // together with the carry register this forms a + ~b + carry.
  assign sliceX = aOp_q[NIB*sliceCnt_q +: NIB];
  assign sliceY = ~bOp_q[NIB*sliceCnt_q +: NIB];

  cla4_slice u_slice (
    .x  (sliceX),
    .y  (sliceY),
    .ci (carry_q),
    .s  (sliceSum),
    .co (sliceCo)
  );

  // Controller next-state: latch operands on accept, walk the nibbles in
  // RUN, and hold the result in DONE until the consumer takes it. A new
  // request seen while DONE is deliberately not taken in the same cycle.
  always_comb begin
    state_d    = state_q;
    sliceCnt_d = sliceCnt_q;
    carry_d    = carry_q;
    aOp_d      = aOp_q;
    bOp_d      = bOp_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          aOp_d      = a;
          bOp_d      = b;
          sliceCnt_d = '0;
          carry_d    = ~borrow_in;
          state_d    = RUN;
        end
      end
      RUN: begin
        diff_d[NIB*sliceCnt_q +: NIB] = sliceSum;
        carry_d    = sliceCo;
        sliceCnt_d = sliceCnt_q + 1'b1;
        if (lastSlice) begin
          borrow_d = ~sliceCo;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All datapath and control registers clear on reset, which aborts any
  // operation in flight and zeroes the visible result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sliceCnt_q <= '0;
      carry_q    <= 1'b0;
      aOp_q      <= '0;
      bOp_q      <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sliceCnt_q <= sliceCnt_d;
      carry_q    <= carry_d;
      aOp_q      <= aOp_d;
      bOp_q      <= bOp_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;

`ifdef CLA_SUB_OVERFLOW_EN
  logic aMsb_q;
  logic bMsb_q;
  logic ovf_q;
  logic ovf_d;

  // Signed overflow: operand signs differ and the result sign departs from
  // the minuend. The top nibble's sum MSB is the final diff MSB, so the
  // flag is captured on the same edge that enters DONE.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && lastSlice) begin
      ovf_d = (aMsb_q != bMsb_q) && (sliceSum[NIB-1] != aMsb_q);
    end
  end

  // Operand sign bits are captured alongside the operands on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aMsb_q <= 1'b0;
      bMsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        aMsb_q <= a[WIDTH-1];
        bMsb_q <= b[WIDTH-1];
      end
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cla_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_cla_serial_sub
// Self-checking bench for cla_serial_sub (WIDTH=16). A queue-based model
// computes the expected result of each accepted operation with plain
// arithmetic; a compare process checks the outputs every cycle.
// ---------------------------------------------------------------------------
module tb_cla_serial_sub;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    int           acceptCycle;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  logic prevOv = 1'b0;

  cla_serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from the arithmetic definition: extend to W+1 bits so
  // the top bit of the wrapped difference is exactly the unsigned borrow.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic bi, input int cyc);
    exp_t        e;
    logic [W:0]  full;
    full   = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    e.diff = full[W-1:0];
    e.borrow = full[W];
`ifdef CLA_SUB_OVERFLOW_EN
    e.ovf = (av[W-1] != bv[W-1]) && (e.diff[W-1] != av[W-1]);
`else
    e.ovf = 1'b0;
`endif
    e.acceptCycle = cyc;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Model bookkeeping on each rising edge: the block is idle exactly when no
  // operation is outstanding, so a request is taken only then; a result is
  // retired when it is presented and the consumer is ready.
  always @(posedge clk) begin
    cycle++;
    if (rst_n) begin
      if (out_valid && out_ready && expQ.size() > 0) begin
        void'(expQ.pop_front());
      end else if (in_valid && expQ.size() == 0) begin
        expQ.push_back(model(a, b, borrow_in, cycle));
      end
    end
  end

  // Compare process: on every falling edge check the handshake flags against
  // the model's idea of occupancy, and whenever a result is presented check
  // it, plus the accept-to-valid latency on its first cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expQ.size() == 0});
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          if (!prevOv) begin
            checkOutput("latency", cycle - expQ[0].acceptCycle, N);
          end
          checkOutput("diff", {16'b0, diff}, {16'b0, expQ[0].diff});
          checkOutput("borrow_out", {31'b0, borrow_out}, {31'b0, expQ[0].borrow});
          checkOutput("overflow", {31'b0, overflow}, {31'b0, expQ[0].ovf});
        end
      end
      prevOv = out_valid;
    end else begin
      prevOv = 1'b0;
    end
  end

  // Present operands and hold them until the accepting edge has passed.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic bi);
    int guard = 0;
    a         = av;
    b         = bv;
    borrow_in = bi;
    in_valid  = 1'b1;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDone();
    int guard = 0;
    while (!out_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;

    // Reset values.
    #3;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_diff", {16'b0, diff}, 32'd0);
    checkOutput("rst_borrow", {31'b0, borrow_out}, 32'd0);
    checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Directed cases with hand-computed results.
    applyStimulus(16'h1234, 16'h0234, 1'b0);
    waitDone();
    checkOutput("t1_diff", {16'b0, diff}, 32'h1000);
    checkOutput("t1_borrow", {31'b0, borrow_out}, 32'd0);
    checkOutput("t1_ovf", {31'b0, overflow}, 32'd0);
    consume();

    applyStimulus(16'h0000, 16'h0001, 1'b0);
    waitDone();
    checkOutput("t2_diff", {16'b0, diff}, 32'hFFFF);
    checkOutput("t2_borrow", {31'b0, borrow_out}, 32'd1);
    checkOutput("t2_ovf", {31'b0, overflow}, 32'd0);
    consume();

    applyStimulus(16'h8000, 16'h0001, 1'b0);
    waitDone();
    checkOutput("t3_diff", {16'b0, diff}, 32'h7FFF);
    checkOutput("t3_borrow", {31'b0, borrow_out}, 32'd0);
`ifdef CLA_SUB_OVERFLOW_EN
    checkOutput("t3_ovf", {31'b0, overflow}, 32'd1);
`else
    checkOutput("t3_ovf", {31'b0, overflow}, 32'd0);
`endif
    consume();

    applyStimulus(16'h0005, 16'h0005, 1'b1);
    waitDone();
    checkOutput("t4_diff", {16'b0, diff}, 32'hFFFF);
    checkOutput("t4_borrow", {31'b0, borrow_out}, 32'd1);
    consume();

    // Backpressure with a competing request held on the input.
    applyStimulus(16'h4321, 16'h1111, 1'b0);
    waitDone();
    a         = 16'hAAAA;
    b         = 16'h5555;
    borrow_in = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_diff", {16'b0, diff}, 32'h3210);
      @(negedge clk);
    end
    consume();
    checkOutput("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("bp_idle_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_second_taken", {31'b0, in_ready}, 32'd0);
    waitDone();
    checkOutput("bp_second_diff", {16'b0, diff}, 32'h5555);
    consume();

    // Asynchronous reset while slice 2 is being processed.
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rr_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rr_diff", {16'b0, diff}, 32'd0);
    checkOutput("rr_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rr_borrow", {31'b0, borrow_out}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    waitDone();
    checkOutput("rr_post_diff", {16'b0, diff}, 32'hFFFE);
    checkOutput("rr_post_borrow", {31'b0, borrow_out}, 32'd0);
    consume();

    // Randomized operations with random consumer delay.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      waitDone();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_serial_sub.md
# cla_serial_sub

Nibble-serial two's-complement subtractor computing `diff = a - b - borrow_in` over `WIDTH` bits. It processes one 4-bit slice per clock through a single 4-bit carry-look-ahead slice and carries the borrow between slices in a register. It is the subtract-side counterpart of the team's 4-bit CLA adder and sits behind a valid/ready operand interface in the datapath.

## Interface
- `WIDTH`, default 16: operand width. Must be a multiple of 4 and at least 4. `N = WIDTH/4` slices.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `a` in WIDTH: minuend.
- `b` in WIDTH: subtrahend.
- `borrow_in` in 1: incoming borrow.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `diff` out WIDTH: `a - b - borrow_in`, modulo 2^WIDTH.
- `borrow_out` out 1: set when unsigned `a < b + borrow_in`.
- `overflow` out 1: signed overflow (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- `in_ready = (state == IDLE)`. `out_valid = (state == DONE)`.
- IDLE → RUN on `in_valid && in_ready`:
  - latch `a`, `b` and `a[WIDTH-1]`, `b[WIDTH-1]`;
  - slice counter ← 0;
  - carry register ← `~borrow_in`.
- RUN, slice `i` (counter = i):
  - `{c, s} = a[4i+3:4i] + ~b[4i+3:4i] + c` via the CLA slice;
  - `s` is written to `diff[4i+3:4i]`;
  - carry register ← `c`;
  - counter increments.
- On slice `N-1`:
  - go to DONE;
  - `borrow_out ← ~c`;
  - overflow is evaluated from the final `diff` MSB.
- DONE: `diff`, `borrow_out` and `overflow` hold stable. On `out_ready` → IDLE.
- DONE with `out_ready` and `in_valid` both high: the result is consumed and the state goes to IDLE. The input is NOT accepted that cycle (`in_ready = 0`); it is taken on the next cycle at the earliest.
- `in_valid` in RUN or DONE is ignored. The latched operands are never overwritten mid-operation.
- `diff` retains the previous result until overwritten slice by slice during the next RUN.

## Timing
- Reset values: `in_ready = 1`, `out_valid = 0`, `diff = 0`, `borrow_out = 0`, `overflow = 0`. All internal registers are 0, state is IDLE.
- Reset asserted mid-RUN or in DONE aborts the operation immediately (asynchronous). Outputs take their reset values while `rst_n` is low.
- Latency: operands accepted at edge k → `out_valid` high after edge k+N. For WIDTH=16 that is 4 cycles.
- Throughput: at most one operation per N+2 cycles (accept, N RUN cycles, DONE handshake, IDLE).
- `out_valid` stays high indefinitely under backpressure. Outputs are constant while `out_valid && !out_ready`.
- No combinational path from any input to any output except `in_ready` and `out_valid`, which are decoded from the state register only.

## Configuration
- Macro: `CLA_SUB_OVERFLOW_EN`.
- Defined:
  - `overflow = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb)`;
  - registered on entry to DONE, held with `diff`;
  - `borrow_in` does not alter the rule.
- Undefined: the `overflow` port is still present and tied to 0, and there are no MSB latch registers.

## Structure
- Shared package `cla_pkg`:
  - state enum `{IDLE, RUN, DONE}`;
  - localparam `NIB = 4`;
  - slice-count helper function `nslices(WIDTH)`.
- Sub-module `cla4_slice`: purely combinational 4-bit CLA.
  - Inputs: `x[3:0]`, `y[3:0]`, `ci`.
  - Outputs: `s[3:0]`, `co`.
  - Uses generate/propagate terms `g = x&y`, `p = x^y` and look-ahead carries `c1..c4`.
- Exactly one instance. The top level owns the FSM, counter, carry register and result registers.

## Test plan
- WIDTH=16, a=0x1234, b=0x0234, borrow_in=0 → diff=0x1000, borrow_out=0, overflow=0. `out_valid` rises exactly 4 edges after accept.
- a=0x0000, b=0x0001, borrow_in=0 → diff=0xFFFF, borrow_out=1, overflow=0.
- a=0x8000, b=0x0001 → diff=0x7FFF, borrow_out=0. overflow=1 with `CLA_SUB_OVERFLOW_EN`, 0 without.
- a=0x0005, b=0x0005, borrow_in=1 → diff=0xFFFF, borrow_out=1.
- Backpressure: hold `out_ready=0` for 10 cycles in DONE while driving new `in_valid` → outputs stable, `in_ready=0`, second operand ignored. Pulse `out_ready` → IDLE next cycle, `in_ready=1`, the new operand is accepted one cycle later.
- Reset pulse during RUN slice 2 → `out_valid=0`, diff=0, `in_ready=1` immediately. A following a=0xFFFF, b=0x0001 operation yields diff=0xFFFE, borrow_out=0.
